chain_decoder: RTL and testbench

Downstream consumer of the chain-code encoder. Latches the start pixel and perimeter, accepts the 3-bit chain-code stream, and redraws the traced boundary into a private 64x64 bitmap. Checks closure and bounds, counts distinct boundary pixels, and tracks the bounding box. It then streams the bitmap out row by row for display or for comparison against the source image.

---
 rtl/chain_pkg.sv | 23 ++
 rtl/chain_step.sv | 30 +++
 rtl/chain_decoder.sv | 196 +++++++++++++++++++
 tb/tb_chain_decoder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chain_pkg.sv
// Shared definitions for the chain-code decoder: geometry, FSM states and
// the direction-to-delta tables used by the position stepper.
package chain_pkg;

    localparam int DIM = 64;
    localparam int CW  = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACCEPT  = 3'd2,
        S_CHECK   = 3'd3,
        S_READOUT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Row/column deltas indexed by chain code (row grows downward).
    localparam logic signed [1:0] DROW [8] = '{2'sb00, 2'sb11, 2'sb11, 2'sb11,
                                               2'sb00, 2'sb01, 2'sb01, 2'sb01};
    localparam logic signed [1:0] DCOL [8] = '{2'sb01, 2'sb01, 2'sb00, 2'sb11,
                                               2'sb11, 2'sb11, 2'sb00, 2'sb01};

endpackage

// File: rtl/chain_step.sv
// Combinational stepper: current position plus chain code gives the next
// position and a flag when the move would leave the image.
module chain_step
    import chain_pkg::*;
(
    input  logic [CW-1:0] row_i,
    input  logic [CW-1:0] col_i,
    input  logic [2:0]    code_i,
    output logic [CW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          oor_o
);

    logic signed [CW:0] row_s;
    logic signed [CW:0] col_s;
    logic signed [1:0]  dr;
    logic signed [1:0]  dc;

    // One extra bit: -1 and 64 both set the top bit, so it is the range flag.
    always_comb begin
        dr    = DROW[code_i];
        dc    = DCOL[code_i];
        row_s = $signed({1'b0, row_i}) + $signed({{(CW-1){dr[1]}}, dr});
        col_s = $signed({1'b0, col_i}) + $signed({{(CW-1){dc[1]}}, dc});
        row_o = row_s[CW-1:0];
        col_o = col_s[CW-1:0];
        oor_o = row_s[CW] | col_s[CW];
    end

endmodule

// File: rtl/chain_decoder.sv
// Chain-code decoder: redraws a traced boundary into a 64x64 bitmap,
// checks closure/bounds, tracks count and bounding box, then streams rows.
module chain_decoder
    import chain_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] start_x,
    input  logic [CW-1:0] start_y,
    input  logic [8:0]    perimeter,
    input  logic [7:0]    code,
    input  logic          code_valid,
    output logic          code_ready,
    output logic [DIM-1:0] row_data,
    output logic [CW-1:0] row_index,
    output logic          row_valid,
    output logic [11:0]   pixel_count,
    output logic [CW-1:0] min_row,
    output logic [CW-1:0] max_row,
    output logic [CW-1:0] min_col,
    output logic [CW-1:0] max_col,
    output logic          busy,
    output logic          done,
    output logic          error,
    output state_t        dbg_state
);

    // Handshake: a code transfers on a rising edge where code_valid and
    // code_ready are both high; code_ready is a pure decode of ACCEPT and
    // does not depend on code_valid. Codes offered elsewhere are dropped.

    state_t         state_q;
    logic [CW-1:0]  sx_q, sy_q, pos_r_q, pos_c_q, cnt_q;
    logic [8:0]     perim_q, acc_q;
    logic [11:0]    pix_q;
    logic [CW-1:0]  min_r_q, max_r_q, min_c_q, max_c_q;
    logic           busy_q, done_q, err_q, row_valid_q;
    logic [DIM-1:0] row_data_q;
    logic [CW-1:0]  row_idx_q;
    logic [DIM-1:0] bitmap_q [DIM];

    logic [CW-1:0]  nxt_r, nxt_c;
    logic           nxt_oor;
    logic           xfer;
    logic [DIM-1:0] nxt_row_bits;
    logic           nxt_is_new;
    logic           bm_we;
    logic [CW-1:0]  bm_addr;
    logic [DIM-1:0] bm_wdata;
    logic           unused_code_bits;

    assign unused_code_bits = ^code[7:3];
    assign code_ready   = (state_q == S_ACCEPT);
    assign xfer         = code_ready && code_valid;
    assign nxt_row_bits = bitmap_q[nxt_r];
    assign nxt_is_new   = ~nxt_row_bits[nxt_c];

    chain_step u_step (
        .row_i  (pos_r_q),
        .col_i  (pos_c_q),
        .code_i (code[2:0]),
        .row_o  (nxt_r),
        .col_o  (nxt_c),
        .oor_o  (nxt_oor)
    );

    // Single bitmap write port: row clear during CLEAR, pixel set on a move.
    always_comb begin
        bm_we    = 1'b0;
        bm_addr  = cnt_q;
        bm_wdata = '0;
        if (state_q == S_CLEAR) begin
            bm_we    = 1'b1;
            bm_wdata = (cnt_q == sx_q) ? (64'd1 << sy_q) : '0;
        end else if (xfer && !nxt_oor) begin
            bm_we    = 1'b1;
            bm_addr  = nxt_r;
            bm_wdata = nxt_row_bits | (64'd1 << nxt_c);
        end
    end

    // Bitmap storage; deliberately not reset since CLEAR initialises it.
    always_ff @(posedge clk) begin
        if (bm_we) bitmap_q[bm_addr] <= bm_wdata;
    end

    // Control FSM with all status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            pos_r_q     <= '0;
            pos_c_q     <= '0;
            cnt_q       <= '0;
            perim_q     <= '0;
            acc_q       <= '0;
            pix_q       <= '0;
            min_r_q     <= '0;
            max_r_q     <= '0;
            min_c_q     <= '0;
            max_c_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            row_valid_q <= 1'b0;
            row_data_q  <= '0;
            row_idx_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sx_q    <= start_x;
                        sy_q    <= start_y;
                        perim_q <= perimeter;
                        pos_r_q <= start_x;
                        pos_c_q <= start_y;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        pix_q   <= 12'd1;
                        min_r_q <= start_x;
                        max_r_q <= start_x;
                        min_c_q <= start_y;
                        max_c_q <= start_y;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        if (perim_q == 9'd0) begin
                            err_q   <= 1'b1;
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_ACCEPT;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (code_valid) begin
                        acc_q <= acc_q + 9'd1;
                        if (nxt_oor) begin
                            err_q <= 1'b1;
                        end else begin
                            pos_r_q <= nxt_r;
                            pos_c_q <= nxt_c;
                            if (nxt_is_new) pix_q <= pix_q + 12'd1;
                            if (nxt_r < min_r_q) min_r_q <= nxt_r;
                            if (nxt_r > max_r_q) max_r_q <= nxt_r;
                            if (nxt_c < min_c_q) min_c_q <= nxt_c;
                            if (nxt_c > max_c_q) max_c_q <= nxt_c;
                        end
                        if (acc_q + 9'd1 == perim_q) state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (pos_r_q != sx_q || pos_c_q != sy_q) err_q <= 1'b1;
                    row_data_q  <= bitmap_q[0];
                    row_idx_q   <= '0;
                    row_valid_q <= 1'b1;
                    state_q     <= S_READOUT;
                end
                S_READOUT: begin
                    if (row_idx_q == 6'd63) begin
                        row_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        row_idx_q  <= row_idx_q + 6'd1;
                        row_data_q <= bitmap_q[row_idx_q + 6'd1];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign row_data    = row_data_q;
    assign row_index   = row_idx_q;
    assign row_valid   = row_valid_q;
    assign pixel_count = pix_q;
    assign min_row     = min_r_q;
    assign max_row     = max_r_q;
    assign min_col     = min_c_q;
    assign max_col     = max_c_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_chain_decoder.sv
// Bench for chain_decoder: directed scenarios plus randomized paths checked
// against a bitmap-level reference model.
module tb_chain_decoder;
    import chain_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  start_x = '0;
    logic [5:0]  start_y = '0;
    logic [8:0]  perimeter = '0;
    logic [7:0]  code = '0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [63:0] row_data;
    logic [5:0]  row_index;
    logic        row_valid;
    logic [11:0] pixel_count;
    logic [5:0]  min_row, max_row, min_col, max_col;
    logic        busy, done, error;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;

    // Reference model: plain bitmap, integer position, sticky error.
    logic [63:0] m_bm [64];
    int          m_r, m_c;
    logic        m_err;
    int          code_q[$];

    // clock
    always #5 clk = ~clk;

    chain_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_x     (start_x),
        .start_y     (start_y),
        .perimeter   (perimeter),
        .code        (code),
        .code_valid  (code_valid),
        .code_ready  (code_ready),
        .row_data    (row_data),
        .row_index   (row_index),
        .row_valid   (row_valid),
        .pixel_count (pixel_count),
        .min_row     (min_row),
        .max_row     (max_row),
        .min_col     (min_col),
        .max_col     (max_col),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int r = 0; r < 64; r++) n += $countones(m_bm[r]);
        return n;
    endfunction

    task automatic m_bbox(output int r0, output int r1, output int c0, output int c1);
        r0 = 63; r1 = 0; c0 = 63; c1 = 0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                if (m_bm[r][c]) begin
                    if (r < r0) r0 = r;
                    if (r > r1) r1 = r;
                    if (c < c0) c0 = c;
                    if (c > c1) c1 = c;
                end
    endtask

    task automatic m_init(input int sx, input int sy, input int per);
        for (int r = 0; r < 64; r++) m_bm[r] = '0;
        m_bm[sx][sy] = 1'b1;
        m_r   = sx;
        m_c   = sy;
        m_err = (per == 0);
    endtask

    task automatic m_apply(input int c);
        int dr, dc, nr, nc;
        dr = (c >= 1 && c <= 3) ? -1 : (c >= 5) ? 1 : 0;
        dc = (c == 0 || c == 1 || c == 7) ? 1 : (c >= 3 && c <= 5) ? -1 : 0;
        nr = m_r + dr;
        nc = m_c + dc;
        if (nr < 0 || nr >= DIM || nc < 0 || nc >= DIM) begin
            m_err = 1'b1;
        end else begin
            m_r = nr;
            m_c = nc;
            m_bm[nr][nc] = 1'b1;
        end
    endtask

    // Full run: start, CLEAR with code_valid held high, codes with random
    // gaps, CHECK, 64-row readout, final status.
    task automatic run_case(input int sx, input int sy, input int per, input int gap_pct);
        int lows, idx, budget, r0, r1, c0, c1;
        logic go;
        m_init(sx, sy, per);
        start     = 1'b1;
        start_x   = 6'(sx);
        start_y   = 6'(sy);
        perimeter = 9'(per);
        tick();
        start      = 1'b0;
        code_valid = 1'b1;
        code       = {5'($urandom), 3'(code_q.size() > 0 ? code_q[0] : 0)};
        lows = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) tick();
            if (i == 10) begin
                start   = 1'b1;
                start_x = ~6'(sx);
                start_y = ~6'(sy);
            end else begin
                start   = 1'b0;
                start_x = 6'(sx);
                start_y = 6'(sy);
            end
            if (code_ready === 1'b0 && busy === 1'b1) lows++;
        end
        start = 1'b0;
        chk("clear_ready_low", 64'(lows), 64);
        tick();
        chk("pix_after_clear", 64'(pixel_count), 1);
        idx = 0;
        budget = 0;
        if (per > 0) begin
            while (idx < per && budget < 8 * per + 16) begin
                chk("ready_in_accept", 64'(code_ready), 1);
                go = ($urandom_range(0, 99) >= gap_pct);
                code_valid = go;
                code = {5'($urandom), 3'(code_q[idx])};
                tick();
                budget++;
                if (go) begin
                    m_apply(code_q[idx]);
                    idx++;
                    chk("pix_step", 64'(pixel_count), 64'(m_count()));
                end
            end
            chk("codes_consumed", 64'(idx), 64'(per));
        end
        code_valid = 1'b0;
        chk("state_check", 64'(dbg_state), 64'(S_CHECK));
        chk("row_valid_in_check", 64'(row_valid), 0);
        if (m_r != sx || m_c != sy) m_err = 1'b1;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("row_valid", 64'(row_valid), 1);
            chk("row_index", 64'(row_index), 64'(i));
            chk($sformatf("row_data[%0d]", i), row_data, m_bm[i]);
            chk("done_early", 64'(done), 0);
        end
        tick();
        m_bbox(r0, r1, c0, c1);
        chk("done", 64'(done), 1);
        chk("busy_done", 64'(busy), 0);
        chk("row_valid_done", 64'(row_valid), 0);
        chk("error", 64'(error), 64'(m_err));
        chk("pixel_count", 64'(pixel_count), 64'(m_count()));
        chk("min_row", 64'(min_row), 64'(r0));
        chk("max_row", 64'(max_row), 64'(r1));
        chk("min_col", 64'(min_col), 64'(c0));
        chk("max_col", 64'(max_col), 64'(c1));
        chk("state_done", 64'(dbg_state), 64'(S_DONE));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(code_ready), 0);
        chk({tag, "_row_valid"}, 64'(row_valid), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_error"}, 64'(error), 0);
        chk({tag, "_row_data"}, row_data, 0);
        chk({tag, "_row_index"}, 64'(row_index), 0);
        chk({tag, "_pix"}, 64'(pixel_count), 0);
        chk({tag, "_bbox"}, 64'({min_row, max_row, min_col, max_col}), 0);
        chk({tag, "_state"}, 64'(dbg_state), 64'(S_IDLE));
    endtask

    initial begin
        int k, sx, sy, c;
        // reset
        reset = 1'b1;
        tick();
        tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // 2x2 square
        code_q = {0, 6, 4, 2};
        run_case(10, 20, 4, 0);
        // open path
        code_q = {0, 0, 0};
        run_case(5, 5, 3, 30);
        // out of range at the corner
        code_q = {2, 4};
        run_case(0, 0, 2, 0);
        // perimeter 0 at the far corner
        code_q = {};
        run_case(63, 63, 0, 0);

        // reset in the middle of ACCEPT after 2 of 4 codes
        start = 1'b1; start_x = 6'd30; start_y = 6'd30; perimeter = 9'd4;
        tick();
        start = 1'b0;
        for (int i = 0; i < 64; i++) tick();
        code_valid = 1'b1; code = 8'd0;
        tick();
        tick();
        code_valid = 1'b0;
        chk("abort_pix", 64'(pixel_count), 3);
        reset = 1'b1;
        tick();
        chk_reset_vals("midreset");
        reset = 1'b0;
        tick();
        code_q = {6};
        run_case(30, 30, 1, 0);

        // randomized: closed out-and-back paths and free random walks
        for (int t = 0; t < 8; t++) begin
            code_q = {};
            k  = $urandom_range(1, 12);
            sx = $urandom_range(0, 63);
            sy = $urandom_range(0, 63);
            for (int i = 0; i < k; i++) code_q.push_back($urandom_range(0, 7));
            if (t % 2 == 0) begin
                for (int i = k - 1; i >= 0; i--) begin
                    c = (code_q[i] + 4) % 8;
                    code_q.push_back(c);
                end
            end
            run_case(sx, sy, code_q.size(), $urandom_range(0, 50));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
